// File: rtl/mem_bist_pkg.sv
// rtl/mem_bist_pkg.sv - shared widths, FSM state encoding and expected-data function for mem_bist
package mem_bist_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    CHK,
    FIN
  } state_t;

  // D(a) = pattern ^ a, bitwise inverted when inv is set
  function automatic logic [DATA_W-1:0] exp_data(input logic [DATA_W-1:0] pattern,
                                                 input logic [ADDR_W-1:0] a,
                                                 input logic              inv);
    return pattern ^ {{(DATA_W-ADDR_W){1'b0}}, a} ^ {DATA_W{inv}};
  endfunction

endpackage

// File: rtl/mem_bist_pgen.sv
// rtl/mem_bist_pgen.sv - address counter plus expected data for the current and next address
module mem_bist_pgen
  import mem_bist_pkg::*;
#(
  parameter logic [DATA_W-1:0] PATTERN = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              clr,
  input  logic              inc,
  input  logic              inv,
  output logic [ADDR_W-1:0] a,
  output logic [ADDR_W-1:0] nxt_a,
  output logic              last,
  output logic [DATA_W-1:0] exp,
  output logic [DATA_W-1:0] nxt_exp
);

  // The counter wraps 31 -> 0, which is exactly the restart needed between phases
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      a <= '0;
    end else if (clr) begin
      a <= '0;
    end else if (inc) begin
      a <= nxt_a;
    end
  end

  assign nxt_a   = a + 1'b1;
  assign last    = (a == ADDR_LAST);
  assign exp     = exp_data(PATTERN, a, inv);
  assign nxt_exp = exp_data(PATTERN, nxt_a, inv);

endmodule

// File: rtl/mem_bist.sv
// rtl/mem_bist.sv - write/read-back memory BIST; MEM_BIST_INV_PASS_EN adds an inverted-data second pass
module mem_bist
  import mem_bist_pkg::*;
#(
  parameter logic [DATA_W-1:0] PATTERN = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              start,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [6:0]        err_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  state_t            state;
  logic [ADDR_W-1:0] a;
  logic [ADDR_W-1:0] nxt_a;
  logic              last;
  logic              inv;
  logic [DATA_W-1:0] exp;
  logic [DATA_W-1:0] nxt_exp;

`ifdef MEM_BIST_INV_PASS_EN
  logic inv_pass;
  assign inv = inv_pass;
`else
  assign inv = 1'b0;
`endif

  mem_bist_pgen #(
    .PATTERN(PATTERN)
  ) u_pgen (
    .clk    (clk),
    .rst_   (rst_),
    .clr    (state == IDLE && start),
    .inc    (state == WR || state == CHK),
    .inv    (inv),
    .a      (a),
    .nxt_a  (nxt_a),
    .last   (last),
    .exp    (exp),
    .nxt_exp(nxt_exp)
  );

  // Strobes, addr and data_in are registered one step ahead, so each state
  // loads the values the following cycle must present
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state          <= IDLE;
      read           <= 1'b0;
      write          <= 1'b0;
      addr           <= '0;
      data_in        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
`ifdef MEM_BIST_INV_PASS_EN
      inv_pass       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state          <= WR;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            write          <= 1'b1;
            addr           <= '0;
            data_in        <= exp_data(PATTERN, '0, 1'b0);
`ifdef MEM_BIST_INV_PASS_EN
            inv_pass       <= 1'b0;
`endif
          end
        end
        WR: begin
          if (last) begin
            state   <= RD;
            write   <= 1'b0;
            read    <= 1'b1;
            addr    <= '0;
            data_in <= '0;
          end else begin
            addr    <= nxt_a;
            data_in <= nxt_exp;
          end
        end
        RD: begin
          state <= CHK;
          read  <= 1'b0;
          addr  <= '0;
        end
        CHK: begin
          if (data_out != exp) begin
            if (err_count != '1) begin
              err_count <= err_count + 1'b1;
            end
            if (err_count == '0) begin
              first_err_addr <= a;
            end
          end
          if (!last) begin
            state <= RD;
            read  <= 1'b1;
            addr  <= nxt_a;
`ifdef MEM_BIST_INV_PASS_EN
          end else if (!inv_pass) begin
            state    <= WR;
            inv_pass <= 1'b1;
            write    <= 1'b1;
            addr     <= '0;
            data_in  <= exp_data(PATTERN, '0, 1'b1);
`endif
          end else begin
            state <= FIN;
            busy  <= 1'b0;
          end
        end
        FIN: begin
          state <= IDLE;
          done  <= 1'b1;
          pass  <= (err_count == '0);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bist.sv
// tb/tb_mem_bist.sv - directed self-checking bench for mem_bist with a behavioural 32x8 memory
module tb_mem_bist;

`ifdef MEM_BIST_INV_PASS_EN
  localparam int EXP_BUSY = 192;
  localparam int EXP_ZERO_ERRS = 64;
  localparam logic [7:0] MEM0 = 8'h5A;
  localparam logic [7:0] MEM3 = 8'h59;
  localparam logic [7:0] MEM31 = 8'h45;
`else
  localparam int EXP_BUSY = 96;
  localparam int EXP_ZERO_ERRS = 32;
  localparam logic [7:0] MEM0 = 8'hA5;
  localparam logic [7:0] MEM3 = 8'hA6;
  localparam logic [7:0] MEM31 = 8'hBA;
`endif

  logic       clk = 1'b0;
  logic       rst_ = 1'b0;
  logic       start = 1'b0;
  logic       read, write, busy, done, pass;
  logic [4:0] addr, first_err_addr;
  logic [7:0] data_in;
  logic [7:0] data_out = 8'h00;
  logic [6:0] err_count;

  int   tests = 0;
  int   fails = 0;
  int   mode = 0;
  int   edges, busy_cnt;
  logic prev_read = 1'b0;
  logic prot_bad;
  logic [7:0] mem [32];

  mem_bist dut (
    .clk           (clk),
    .rst_          (rst_),
    .start         (start),
    .read          (read),
    .write         (write),
    .addr          (addr),
    .data_in       (data_in),
    .data_out      (data_out),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_count     (err_count),
    .first_err_addr(first_err_addr)
  );

  always #5 clk = ~clk;

  // mode 0: ideal, 1: bit 0 stuck at 1 at addr 3, 2: always reads 0x00
  always @(posedge clk) begin
    if (write) mem[addr] <= data_in;
    if (read) begin
      case (mode)
        1: data_out <= (addr == 5'd3) ? (mem[addr] | 8'h01) : mem[addr];
        2: data_out <= 8'h00;
        default: data_out <= mem[addr];
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (rst_) begin
      prot_bad = (read && write) || (prev_read && (read || write)) ||
                 (!read && !write && (addr != 5'd0 || data_in != 8'h00));
      chk("protocol", prot_bad, 1'b0);
      prev_read = read;
    end else begin
      prev_read = 1'b0;
    end
  end

  task automatic run(input int restart_at, output int n_edges, output int n_busy);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("accept_busy", busy, 1'b1);
    chk("accept_done", done, 1'b0);
    chk("wr0_write", write, 1'b1);
    chk("wr0_addr", addr, 5'd0);
    chk("wr0_data", data_in, 8'hA5);
    n_edges = 0;
    n_busy = busy ? 1 : 0;
    for (int k = 1; k <= 400; k++) begin
      start = (k == restart_at);
      @(posedge clk);
      #1;
      if (k == 1) chk("wr1_data", data_in, 8'hA4);
      if (k == 2) chk("wr2_data", data_in, 8'hA7);
      if (busy) n_busy++;
      if (done) begin
        n_edges = k;
        break;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_pass", pass, 1'b0);
    chk("rst_rw", {read, write}, 2'b00);
    chk("rst_addr", addr, 5'd0);
    chk("rst_data", data_in, 8'h00);
    chk("rst_err", err_count, 7'd0);
    chk("rst_first", first_err_addr, 5'd0);
    @(negedge clk);
    rst_ = 1'b1;

    mode = 0;
    run(0, edges, busy_cnt);
    chk("ideal_done_edge", edges, EXP_BUSY + 1);
    chk("ideal_busy_cycles", busy_cnt, EXP_BUSY);
    chk("ideal_pass", pass, 1'b1);
    chk("ideal_err", err_count, 7'd0);
    chk("ideal_first", first_err_addr, 5'd0);
    chk("mem0", mem[0], MEM0);
    chk("mem3", mem[3], MEM3);
    chk("mem31", mem[31], MEM31);
    repeat (3) @(posedge clk);
    #1;
    chk("done_held", done, 1'b1);
    chk("pass_held", pass, 1'b1);

    mode = 1;
    run(0, edges, busy_cnt);
    chk("stuck_done_edge", edges, EXP_BUSY + 1);
    chk("stuck_err", err_count, 7'd1);
    chk("stuck_first", first_err_addr, 5'd3);
    chk("stuck_pass", pass, 1'b0);

    mode = 2;
    run(0, edges, busy_cnt);
    chk("zero_err", err_count, EXP_ZERO_ERRS);
    chk("zero_first", first_err_addr, 5'd0);
    chk("zero_pass", pass, 1'b0);

    mode = 0;
    run(10, edges, busy_cnt);
    chk("restart_done_edge", edges, EXP_BUSY + 1);
    chk("restart_busy_cycles", busy_cnt, EXP_BUSY);
    chk("restart_pass", pass, 1'b1);
    chk("restart_err", err_count, 7'd0);

    mode = 2;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("pre_abort_busy", busy, 1'b1);
    chk("pre_abort_err", err_count, 7'd4);
    rst_ = 1'b0;
    #1;
    chk("abort_rw", {read, write}, 2'b00);
    chk("abort_busy", busy, 1'b0);
    chk("abort_addr", addr, 5'd0);
    chk("abort_err", err_count, 7'd0);
    @(negedge clk);
    rst_ = 1'b1;
    mode = 0;
    repeat (5) @(posedge clk);
    #1;
    chk("no_resume_busy", busy, 1'b0);
    chk("no_resume_done", done, 1'b0);
    run(0, edges, busy_cnt);
    chk("post_abort_done_edge", edges, EXP_BUSY + 1);
    chk("post_abort_pass", pass, 1'b1);
    chk("post_abort_err", err_count, 7'd0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
